// File: rtl/occ_pkg.sv
// occ_pkg: shared seven-segment types and glyph constants for occupancy_display.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package occ_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000011, 7'b1111000, 7'b0000000, 7'b0011000
  };

  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_M = 7'b1101010;
  localparam seg7_t SEG_P = 7'b0001100;
  localparam seg7_t SEG_T = 7'b0000111;
  localparam seg7_t SEG_Y = 7'b0010001;
  localparam seg7_t SEG_F = 7'b0001110;
  localparam seg7_t SEG_U = 7'b1000001;
  localparam seg7_t SEG_L = 7'b1000111;

endpackage

// File: rtl/seg7_digit.sv
// seg7_digit: combinational BCD-to-seven-segment decoder (active-low).
// Codes 10..15 are not decimal digits and produce a blank glyph.
module seg7_digit
  import occ_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  // Look up the glyph for one decimal digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/occupancy_display.sv
// occupancy_display: saturating 0..CAPACITY occupancy counter driving six
// registered seven-segment digits ("EmPty0", "FULL"+count, or the count).
// Optional feature macro OCC_BLINK_EN: blink the FULL glyphs while at capacity
// with a half-period of BLINK_DIV clock cycles.
module occupancy_display
  import occ_pkg::*;
#(
  parameter  int CAPACITY  = 25,
  parameter  int BLINK_DIV = 25_000_000,
  localparam int CW        = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output seg7_t         HEX5,
  output seg7_t         HEX4,
  output seg7_t         HEX3,
  output seg7_t         HEX2,
  output seg7_t         HEX1,
  output seg7_t         HEX0
);

  localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  localparam logic [5:0][6:0] EMPTY_PAT = {SEG_E, SEG_M, SEG_P, SEG_T, SEG_Y, SEG_DIGIT[0]};
  localparam logic [3:0][6:0] FULL_PAT  = {SEG_F, SEG_U, SEG_L, SEG_L};
  localparam logic [3:0][6:0] BLANK4    = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};

  // Out-of-range configurations stop elaboration
  if ((CAPACITY < 32'sd1) || (CAPACITY > 32'sd99) || (BLINK_DIV < 32'sd2)) begin : g_bad_params
    $error("occupancy_display: CAPACITY must be 1..99 and BLINK_DIV >= 2");
  end

  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic [5:0][6:0] hex_r;
  logic [5:0][6:0] hex_nxt_s;
  logic            full_s;
  logic            empty_s;
  logic            show_full_s;
  logic [6:0]      count_ext_s;
  logic [3:0]      tens_s;
  logic [3:0]      ones_s;
  seg7_t           tens_seg_s;
  seg7_t           ones_seg_s;

  assign full_s  = (count_r == CAP_C);
  assign empty_s = (count_r == ZERO_C);

  // Widen to 7 bits so the divide/modulo by ten is legal for any CW
  assign count_ext_s = 7'(count_r);
  assign tens_s      = 4'(count_ext_s / 7'd10);
  assign ones_s      = 4'(count_ext_s % 7'd10);

  seg7_digit u_tens (.bcd(tens_s), .seg(tens_seg_s));
  seg7_digit u_ones (.bcd(ones_s), .seg(ones_seg_s));

  // Saturating next count: lone inc/dec moves it, anything else holds
  always_comb begin
    count_nxt_s = count_r;
    if (inc && !dec && (count_r < CAP_C)) begin
      count_nxt_s = count_r + ONE_C;
    end else if (dec && !inc && (count_r > ZERO_C)) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

`ifdef OCC_BLINK_EN
  localparam int PW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRE_TC   = PW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(0);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] pre_r;
  logic          phase_r;

  // Blink timebase: runs only while full, parked at zero/on otherwise
  always_ff @(posedge clk) begin
    if (reset || !full_s) begin
      pre_r   <= PRE_ZERO;
      phase_r <= 1'b1;
    end else if (pre_r == PRE_TC) begin
      pre_r   <= PRE_ZERO;
      phase_r <= ~phase_r;
    end else begin
      pre_r   <= pre_r + PRE_ONE;
      phase_r <= phase_r;
    end
  end

  assign show_full_s = phase_r;
`else
  assign show_full_s = 1'b1;
`endif

  // Decode the current count into the glyphs the display loads next edge
  always_comb begin
    hex_nxt_s = EMPTY_PAT;
    if (empty_s) begin
      hex_nxt_s = EMPTY_PAT;
    end else if (full_s) begin
      if (show_full_s) begin
        hex_nxt_s[5:2] = FULL_PAT;
      end else begin
        hex_nxt_s[5:2] = BLANK4;
      end
      hex_nxt_s[1] = tens_seg_s;
      hex_nxt_s[0] = ones_seg_s;
    end else begin
      hex_nxt_s[5:2] = BLANK4;
      if (tens_s == 4'd0) begin
        hex_nxt_s[1] = SEG_BLANK;
      end else begin
        hex_nxt_s[1] = tens_seg_s;
      end
      hex_nxt_s[0] = ones_seg_s;
    end
  end

  // Occupancy and display registers; reset shows EmPty0 on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO_C;
      hex_r   <= EMPTY_PAT;
    end else begin
      count_r <= count_nxt_s;
      hex_r   <= hex_nxt_s;
    end
  end

  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;
  assign HEX5  = hex_r[5];
  assign HEX4  = hex_r[4];
  assign HEX3  = hex_r[3];
  assign HEX2  = hex_r[2];
  assign HEX1  = hex_r[1];
  assign HEX0  = hex_r[0];

endmodule
